dls_fault_manager: RTL
======================

DLS_FAULT_MANAGER -- requirements
Module: dls_fault_manager

Interface
REQ-001 SHALL have parameter THRESHOLD, default 3: consecutive DLS_ERROR cycles needed to declare a fault, legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 16: width of ERR_COUNT.
REQ-003 SHALL have port HCLK, input, 1: the single clock; all logic rises on posedge HCLK.
REQ-004 SHALL have port HRESET, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port DLS_ERROR, input, 1: per-cycle lockstep mismatch flag from the DLS comparator.
REQ-006 SHALL have port HSYNC, input, 1: primary-channel horizontal sync.
REQ-007 SHALL have port VSYNC, input, 1: primary-channel vertical sync.
REQ-008 SHALL have port RGB, input, 8: primary-channel pixel.
REQ-009 SHALL have port CLEAR, input, 1: software fault-clear and counter-clear request, sampled each cycle.
REQ-010 SHALL have port HSYNC_OUT, output, 1: registered sync to the pad.
REQ-011 SHALL have port VSYNC_OUT, output, 1: registered sync to the pad.
REQ-012 SHALL have port RGB_OUT, output, 8: registered pixel to the pad, blanked on fault.
REQ-013 SHALL have port FAULT, output, 1: high while in state FAULT.
REQ-014 SHALL have port FAULT_IRQ, output, 1: one-cycle pulse on entry to FAULT.
REQ-015 SHALL have port ERR_COUNT, output, CNT_W: saturating count of mismatch cycles.
REQ-016 SHALL have port FAULT_COUNT, output, 8: saturating count of FAULT entries.

Function
REQ-017 SHALL implement the states MONITOR, SUSPECT and FAULT, with a run counter RUN (8 bits).
REQ-018 In MONITOR with DLS_ERROR=1, SHALL go to FAULT if THRESHOLD=1; otherwise it SHALL go to SUSPECT with RUN=1.
REQ-019 In MONITOR with DLS_ERROR=0, SHALL stay in MONITOR with RUN=0.
REQ-020 In SUSPECT with DLS_ERROR=1, SHALL increment RUN; when RUN+1 equals THRESHOLD it SHALL go to FAULT and set RUN=0.
REQ-021 In SUSPECT with DLS_ERROR=0, SHALL return to MONITOR and set RUN=0; RUN SHALL never accumulate across non-consecutive errors.
REQ-022 In FAULT, SHALL stay until a cycle with CLEAR=1 and DLS_ERROR=0, then go to MONITOR; CLEAR=1 with DLS_ERROR=1 SHALL keep it in FAULT.
REQ-023 CLEAR SHALL have no effect on state in MONITOR or SUSPECT.
REQ-024 FAULT SHALL be registered and high in the first cycle after the transition edge into FAULT, and for every cycle the state is FAULT.
REQ-025 FAULT_IRQ SHALL be high for exactly the one cycle in which FAULT first rises; it SHALL not re-pulse while FAULT stays high.
REQ-026 The video path SHALL have 1-cycle latency: HSYNC_OUT, VSYNC_OUT and RGB_OUT SHALL be registered from the same-cycle inputs.
REQ-027 RGB_OUT SHALL be 8'h00 in every cycle in which FAULT is high; otherwise it SHALL equal the delayed RGB.
REQ-028 HSYNC_OUT and VSYNC_OUT SHALL always pass through, including during FAULT, so the display stays locked.
REQ-029 ERR_COUNT SHALL increment by 1 on each cycle with DLS_ERROR=1 and saturate at 2^CNT_W-1 with no wrap.
REQ-030 CLEAR=1 SHALL load ERR_COUNT with DLS_ERROR in that cycle (0 or 1), in any state.
REQ-031 FAULT_COUNT SHALL increment on each FAULT entry, saturate at 255, and not be affected by CLEAR.
REQ-032 All counters and the state SHALL update on the same edge, with no combinational path from input to output.

Reset
REQ-033 HRESET=1 at a posedge SHALL force, at the next cycle, state=MONITOR, RUN=0, FAULT=0, FAULT_IRQ=0, ERR_COUNT=0, FAULT_COUNT=0, HSYNC_OUT=1, VSYNC_OUT=1 and RGB_OUT=8'h00.
REQ-034 HRESET SHALL take priority over CLEAR and DLS_ERROR, and SHALL abort SUSPECT or FAULT mid-operation with no IRQ pulse.

Verification
REQ-035 Bench SHALL cover THRESHOLD=3, DLS_ERROR high for 2 cycles then low -> SUSPECT then MONITOR, FAULT=0, ERR_COUNT=2, RGB_OUT tracks RGB delayed by 1.
REQ-036 Bench SHALL cover THRESHOLD=3, DLS_ERROR high for 3 cycles with RGB=8'hA5 -> FAULT=1 and a 1-cycle FAULT_IRQ after the 3rd error edge, RGB_OUT=8'h00, syncs passed, FAULT_COUNT=1.
REQ-037 Bench SHALL cover, in FAULT, CLEAR=1 with DLS_ERROR=1 -> stays in FAULT with ERR_COUNT=1; then CLEAR=1 with DLS_ERROR=0 -> MONITOR, FAULT=0, ERR_COUNT=0, FAULT_COUNT unchanged.
REQ-038 Bench SHALL cover THRESHOLD=1 with a single error cycle -> FAULT on the next edge; the error pattern 1,0,1,0 at THRESHOLD=2 -> never FAULT.
REQ-039 Bench SHALL cover CNT_W=4 with DLS_ERROR held high for 20 cycles -> ERR_COUNT saturates at 15 with no wrap.
REQ-040 Bench SHALL cover HRESET=1 in FAULT -> all outputs at their reset values the next cycle, no FAULT_IRQ.

Source files
------------

// File: rtl/dls_fault_manager.sv
// Lockstep fault manager: debounces DLS comparator mismatches into a latched fault,
// blanks the registered pixel path while faulted and keeps error/fault statistics.
module dls_fault_manager #(
    parameter int THRESHOLD = 3,
    parameter int CNT_W     = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             DLS_ERROR,
    input  logic             HSYNC,
    input  logic             VSYNC,
    input  logic [7:0]       RGB,
    input  logic             CLEAR,
    output logic             HSYNC_OUT,
    output logic             VSYNC_OUT,
    output logic [7:0]       RGB_OUT,
    output logic             FAULT,
    output logic             FAULT_IRQ,
    output logic [CNT_W-1:0] ERR_COUNT,
    output logic [7:0]       FAULT_COUNT
);

    typedef enum logic [1:0] {
        S_MONITOR = 2'd0,
        S_SUSPECT = 2'd1,
        S_FAULT   = 2'd2
    } state_t;

    localparam logic [8:0]       THR     = 9'(THRESHOLD);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_run;
    logic [7:0]       w_run_next;
    logic [8:0]       w_run_inc;

    logic             r_hsync;
    logic             r_vsync;
    logic [7:0]       r_rgb;
    logic             r_fault;
    logic             r_irq;
    logic [CNT_W-1:0] r_err_cnt;
    logic [7:0]       r_fault_cnt;

    logic             w_enter_fault;
    logic             w_fault_next;
    logic [7:0]       w_rgb_next;
    logic [CNT_W-1:0] w_err_cnt_next;
    logic [7:0]       w_fault_cnt_next;

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_MONITOR;
            r_run   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_run   <= w_run_next;
        end
    end

    // Widened so RUN+1 never wraps before the threshold compare
    assign w_run_inc = {1'b0, r_run} + 9'd1;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
        case (r_state)
            S_MONITOR: begin
                w_run_next = 8'd0;
                if (DLS_ERROR) begin
                    if (THRESHOLD == 1) begin
                        w_state_next = S_FAULT;
                    end else begin
                        w_state_next = S_SUSPECT;
                        w_run_next   = 8'd1;
                    end
                end
            end
            S_SUSPECT: begin
                if (DLS_ERROR) begin
                    if (w_run_inc == THR) begin
                        w_state_next = S_FAULT;
                        w_run_next   = 8'd0;
                    end else begin
                        w_run_next = w_run_inc[7:0];
                    end
                end else begin
                    w_state_next = S_MONITOR;
                    w_run_next   = 8'd0;
                end
            end
            S_FAULT: begin
                w_run_next = 8'd0;
                if (CLEAR && !DLS_ERROR) begin
                    w_state_next = S_MONITOR;
                end
            end
            default: begin
                w_state_next = S_MONITOR;
                w_run_next   = 8'd0;
            end
        endcase
    end

    // Output logic: outputs are decoded from the next state so they register on the same edge
    always_comb begin
        w_enter_fault    = (r_state != S_FAULT) && (w_state_next == S_FAULT);
        w_fault_next     = (w_state_next == S_FAULT);
        w_rgb_next       = w_fault_next ? 8'h00 : RGB;

        w_err_cnt_next   = r_err_cnt;
        if (CLEAR) begin
            w_err_cnt_next = {{(CNT_W-1){1'b0}}, DLS_ERROR};
        end else if (DLS_ERROR && (r_err_cnt != ERR_MAX)) begin
            w_err_cnt_next = r_err_cnt + 1'b1;
        end

        w_fault_cnt_next = r_fault_cnt;
        if (w_enter_fault && (r_fault_cnt != 8'hFF)) begin
            w_fault_cnt_next = r_fault_cnt + 8'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_rgb       <= 8'h00;
            r_fault     <= 1'b0;
            r_irq       <= 1'b0;
            r_err_cnt   <= '0;
            r_fault_cnt <= 8'd0;
        end else begin
            r_hsync     <= HSYNC;
            r_vsync     <= VSYNC;
            r_rgb       <= w_rgb_next;
            r_fault     <= w_fault_next;
            r_irq       <= w_enter_fault;
            r_err_cnt   <= w_err_cnt_next;
            r_fault_cnt <= w_fault_cnt_next;
        end
    end

    assign HSYNC_OUT   = r_hsync;
    assign VSYNC_OUT   = r_vsync;
    assign RGB_OUT     = r_rgb;
    assign FAULT       = r_fault;
    assign FAULT_IRQ   = r_irq;
    assign ERR_COUNT   = r_err_cnt;
    assign FAULT_COUNT = r_fault_cnt;

endmodule
